// File: rtl/rbus_pkg.sv
// Shared ring-bus framing constants and frame-tracker state type.
package rbus_pkg;

  localparam int unsigned RBUS_SLOT_SHORT_LEN = 2;
  localparam int unsigned RBUS_SLOT_LONG_LEN  = 9;
  localparam int unsigned RBUS_HDR_TYPE_BIT   = 39;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } rbus_frm_state_t;

endpackage

// File: rtl/rsbus_slot_counter.sv
// Slot position counter: remaining-word count, word index and slot type,
// reloaded on a header by type; o_due flags the cycle a header must arrive.
module rsbus_slot_counter
  import rbus_pkg::*;
#(
  parameter int unsigned SHORT_LEN = RBUS_SLOT_SHORT_LEN,
  parameter int unsigned LONG_LEN  = RBUS_SLOT_LONG_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_load_long,
  input  logic       i_step,
  output logic       o_due,
  output logic       o_long,
  output logic [3:0] o_idx,
  output logic       o_last
);

  localparam logic [3:0] SHORT_M1 = 4'(SHORT_LEN - 1);
  localparam logic [3:0] LONG_M1  = 4'(LONG_LEN - 1);

  logic [3:0] r_rem;
  logic [3:0] r_idx;
  logic       r_long;

  // o_long/o_idx/o_last describe the word presented this cycle.
  assign o_due  = (r_rem == '0);
  assign o_long = i_load ? i_load_long : r_long;
  assign o_idx  = i_load ? '0 : (r_idx + 4'd1);
  assign o_last = (o_idx == (o_long ? LONG_M1 : SHORT_M1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_idx  <= '0;
      r_long <= 1'b0;
    end else if (i_load) begin
      r_rem  <= i_load_long ? LONG_M1 : SHORT_M1;
      r_idx  <= '0;
      r_long <= i_load_long;
    end else if (i_step && (r_rem != '0)) begin
      r_rem <= r_rem - 4'd1;
      r_idx <= r_idx + 4'd1;
    end
  end

endmodule

// File: rtl/rsbus_frame_tracker.sv
// Ring-bus receive frame synchroniser: locks onto the short/long super-frame.
// RSBUS_FRAME_TRACKER_ERRCNT_EN builds the saturating o_err_cnt counter.
module rsbus_frame_tracker
  import rbus_pkg::*;
#(
  parameter int unsigned SHORT_LEN = RBUS_SLOT_SHORT_LEN,
  parameter int unsigned LONG_LEN  = RBUS_SLOT_LONG_LEN,
  parameter int unsigned LOCK_CNT  = 3,
  parameter int unsigned LOSS_CNT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sof,
  input  logic [11:0] i_ctrl,
  input  logic [71:0] i_bus,
  output logic        o_sof,
  output logic [11:0] o_ctrl,
  output logic [71:0] o_bus,
  output logic        o_long,
  output logic [3:0]  o_idx,
  output logic        o_last,
  output logic        o_locked,
  output logic        o_err,
  output logic [15:0] o_err_cnt
);

  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

  rbus_frm_state_t r_state, w_state_nxt;
  logic [3:0] r_good_cnt, w_good_nxt;
  logic [3:0] r_bad_cnt, w_bad_nxt;
  logic       r_exp_long;

  logic       w_hdr_long, w_tracking, w_type_ok, w_good_hdr, w_bad;
  logic       w_due, w_load, w_load_long, w_step, w_nxt_locked;
  logic       w_cur_long, w_cur_last;
  logic [3:0] w_cur_idx;

  logic        r_sof, r_long, r_last, r_locked, r_err;
  logic [3:0]  r_idx;
  logic [11:0] r_ctrl;
  logic [71:0] r_bus;

  assign w_hdr_long = i_bus[RBUS_HDR_TYPE_BIT];
  assign w_tracking = (r_state != HUNT);
  assign w_type_ok  = (w_hdr_long == r_exp_long);
  assign w_good_hdr = w_tracking && w_due && i_sof && w_type_ok;
  assign w_bad      = w_tracking && (w_due ? !(i_sof && w_type_ok) : i_sof);
  assign w_step     = w_tracking && !w_due && !i_sof;

  // Lock progress counts accepted long headers; a non-fatal bad slot while
  // locked resyncs to the offending header, or free-runs if none arrived.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_bad_nxt   = r_bad_cnt;
    w_load      = 1'b0;
    w_load_long = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (i_sof && !w_hdr_long) begin
          w_state_nxt = CHECK;
          w_good_nxt  = '0;
          w_load      = 1'b1;
        end
      end
      CHECK: begin
        if (w_bad) begin
          w_state_nxt = HUNT;
        end else if (w_good_hdr) begin
          w_load      = 1'b1;
          w_load_long = w_hdr_long;
          if (w_hdr_long) begin
            w_good_nxt = r_good_cnt + 4'd1;
            if (w_good_nxt == LOCK_C) begin
              w_state_nxt = LOCKED;
              w_bad_nxt   = '0;
            end
          end
        end
      end
      LOCKED: begin
        if (w_good_hdr) begin
          w_load      = 1'b1;
          w_load_long = w_hdr_long;
          w_bad_nxt   = '0;
        end else if (w_bad) begin
          w_bad_nxt = r_bad_cnt + 4'd1;
          if (w_bad_nxt == LOSS_C) begin
            w_state_nxt = HUNT;
          end else begin
            w_load      = 1'b1;
            w_load_long = i_sof ? w_hdr_long : r_exp_long;
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  assign w_nxt_locked = (w_state_nxt == LOCKED);

  rsbus_slot_counter #(
    .SHORT_LEN (SHORT_LEN),
    .LONG_LEN  (LONG_LEN)
  ) u_slot_counter (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_long (w_load_long),
    .i_step      (w_step),
    .o_due       (w_due),
    .o_long      (w_cur_long),
    .o_idx       (w_cur_idx),
    .o_last      (w_cur_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= HUNT;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_exp_long <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_bad_cnt  <= w_bad_nxt;
      if (w_load) r_exp_long <= !w_load_long;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sof    <= 1'b0;
      r_ctrl   <= '0;
      r_bus    <= '0;
      r_long   <= 1'b0;
      r_idx    <= '0;
      r_last   <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_sof    <= i_sof && w_nxt_locked;
      r_ctrl   <= i_ctrl;
      r_bus    <= i_bus;
      r_long   <= w_cur_long && w_nxt_locked;
      r_idx    <= w_nxt_locked ? w_cur_idx : '0;
      r_last   <= w_cur_last && w_nxt_locked;
      r_locked <= w_nxt_locked;
      r_err    <= w_bad;
    end
  end

`ifdef RSBUS_FRAME_TRACKER_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_bad && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = '0;
`endif

  assign o_sof    = r_sof;
  assign o_ctrl   = r_ctrl;
  assign o_bus    = r_bus;
  assign o_long   = r_long;
  assign o_idx    = r_idx;
  assign o_last   = r_last;
  assign o_locked = r_locked;
  assign o_err    = r_err;

endmodule
